// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_pkg: shared types for the register-file write-port arbiter.
//   arbState_t   - arbiter FSM states (IDLE, STALL)
//   wbSource_t   - origin of the write held in the output register
//   queueEntry_t - one queued mul/div result {regNum, data, alive}
//   REG_ZERO     - hardwired-zero register index (writes to it are dropped)
package regfile_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE,
        STALL
    } arbState_t;

    typedef enum logic {
        SRC_PIPE,
        SRC_MD
    } wbSource_t;

    typedef struct packed {
        logic [REG_W-1:0]  regNum;
        logic [DATA_W-1:0] data;
        logic              alive;
    } queueEntry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bundles every non-clock/reset signal of the arbiter.
//   master modport - producers and decode side (drives wb_*, md_valid/reg/data,
//                    rd_addr1/2; observes md_ready, rf_*, stall_pipe, rd_pending*)
//   slave modport  - the arbiter itself (the reverse directions)
interface regfile_wb_arbiter_if;

    // pipeline writeback
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    // mul/div result handshake
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    // register file write port
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    // pipeline control and decode hazard lookup
    logic        stall_pipe;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rd_pending1;
    logic        rd_pending2;

    modport master (
        output wb_valid, wb_reg, wb_data,
        output md_valid, md_reg, md_data,
        input  md_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_pipe,
        output rd_addr1, rd_addr2,
        input  rd_pending1, rd_pending2
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  md_valid, md_reg, md_data,
        output md_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_pipe,
        input  rd_addr1, rd_addr2,
        output rd_pending1, rd_pending2
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// wb_queue: DEPTH-entry FIFO of pending mul/div results.
//   clock, reset_n      - clock, async active-low reset (empties the queue)
//   pushEn, pushEntry   - write pushEntry at the tail
//   popEn               - retire the head entry
//   killEn, killReg     - clear alive on every stored entry whose regNum == killReg
//   matchReg1/2, match1/2 - combinational lookup: an alive entry targets matchRegX
//   head, count         - head entry and occupancy
// Slots are cleared to dead when popped, so alive implies the slot is occupied
// and the match/kill logic needs no occupancy mask.
module wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   pushEn,
    input  queueEntry_t            pushEntry,
    input  logic                   popEn,
    input  logic                   killEn,
    input  logic [REG_W-1:0]       killReg,
    input  logic [REG_W-1:0]       matchReg1,
    input  logic [REG_W-1:0]       matchReg2,
    output logic                   match1,
    output logic                   match2,
    output queueEntry_t            head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    queueEntry_t     entries [DEPTH];
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            // Kill first; the push below lands in an empty slot and therefore
            // keeps its alive bit even when it targets the killed register.
            if (killEn) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (entries[i].regNum == killReg) begin
                        entries[i].alive <= 1'b0;
                    end
                end
            end
            if (popEn) begin
                entries[rdPtr].alive <= 1'b0;
                rdPtr                <= rdPtr + 1'b1;
            end
            if (pushEn) begin
                entries[wrPtr] <= pushEntry;
                wrPtr          <= wrPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].alive && entries[i].regNum == matchReg1) match1 = 1'b1;
            if (entries[i].alive && entries[i].regNum == matchReg2) match2 = 1'b1;
        end
    end

    assign head = entries[rdPtr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the pipeline
// writeback stage (priority) and a queue of mul/div results.
//   clock    - sole clock
//   reset_n  - asynchronous active-low reset
//   bus      - regfile_wb_arbiter_if.slave: wb_* request, md_* handshake,
//              registered rf_* write port and stall_pipe, rd_addr/rd_pending lookup
// A live pipeline write that keeps blocking an alive queued result for
// STARVE_LIMIT cycles moves the FSM to STALL, which asks upstream to hold
// wb_valid low until the head has popped.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

    arbState_t          state, nextState;
    logic [SW-1:0]      starveCnt, nextStarveCnt;
    logic               stallPipe, nextStallPipe;

    logic               rfWe;
    logic [REG_W-1:0]   rfWaddr;
    logic [DATA_W-1:0]  rfWdata;
    wbSource_t          rfSrc;

    queueEntry_t        head;
    queueEntry_t        pushEntry;
    logic [CW-1:0]      count;
    logic               qMatch1, qMatch2;

    logic               liveWb;
    logic               notEmpty;
    logic               full;
    logic               pushEn;
    logic               popEn;
    logic               blocked;

    assign liveWb   = bus.wb_valid && (bus.wb_reg != REG_ZERO);
    assign notEmpty = (count != '0);
    assign full     = (count == CW'(DEPTH));
    // Pushes to r0 complete the handshake but never occupy a slot.
    assign pushEn   = bus.md_valid && !full && (bus.md_reg != REG_ZERO);
    assign popEn    = !liveWb && notEmpty;
    assign blocked  = liveWb && notEmpty && head.alive;

    assign pushEntry = '{regNum: bus.md_reg, data: bus.md_data, alive: 1'b1};

    wb_queue #(
        .DEPTH (DEPTH)
    ) uQueue (
        .clock     (clock),
        .reset_n   (reset_n),
        .pushEn    (pushEn),
        .pushEntry (pushEntry),
        .popEn     (popEn),
        .killEn    (liveWb),
        .killReg   (bus.wb_reg),
        .matchReg1 (bus.rd_addr1),
        .matchReg2 (bus.rd_addr2),
        .match1    (qMatch1),
        .match2    (qMatch2),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            starveCnt <= '0;
            stallPipe <= 1'b0;
        end else begin
            state     <= nextState;
            starveCnt <= nextStarveCnt;
            stallPipe <= nextStallPipe;
        end
    end

    always_comb begin
        nextState     = state;
        nextStarveCnt = starveCnt;
        nextStallPipe = 1'b0;

        case (state)
            IDLE: begin
                if (blocked && starveCnt == STARVE_LAST) nextState = STALL;
            end
            STALL: begin
                if (popEn) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        if (popEn || !notEmpty) begin
            nextStarveCnt = '0;
        end else if (state == IDLE && blocked) begin
            nextStarveCnt = (starveCnt == STARVE_LAST) ? '0 : starveCnt + 1'b1;
        end

        // Raised one cycle after entering STALL and dropped right after the
        // pop, so upstream is held off for the minimum time.
        nextStallPipe = (state == STALL) && !popEn;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rfWe    <= 1'b0;
            rfWaddr <= '0;
            rfWdata <= '0;
            rfSrc   <= SRC_PIPE;
        end else begin
            rfWe <= liveWb || (popEn && head.alive);
            if (liveWb) begin
                rfWaddr <= bus.wb_reg;
                rfWdata <= bus.wb_data;
                rfSrc   <= SRC_PIPE;
            end else if (popEn && head.alive) begin
                rfWaddr <= head.regNum;
                rfWdata <= head.data;
                rfSrc   <= SRC_MD;
            end
        end
    end

    assign bus.md_ready   = !full;
    assign bus.rf_we      = rfWe;
    assign bus.rf_waddr   = rfWaddr;
    assign bus.rf_wdata   = rfWdata;
    assign bus.stall_pipe = stallPipe;

    // A mul/div result sitting in the output register is not yet in the
    // register file, so decode must still treat it as pending.
    assign bus.rd_pending1 = (bus.rd_addr1 != REG_ZERO) &&
        (qMatch1 || (rfWe && rfSrc == SRC_MD && rfWaddr == bus.rd_addr1));
    assign bus.rd_pending2 = (bus.rd_addr2 != REG_ZERO) &&
        (qMatch2 || (rfWe && rfSrc == SRC_MD && rfWaddr == bus.rd_addr2));

endmodule
